// File: rtl/bus_mux_hold.sv
// Shared datapath bus driver: one-hot drive enables select a source word, the
// last driven word is held when nobody drives, and multi-driver cycles are counted.
module bus_mux_hold #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 25,
    parameter int SELW    = $clog2(NSRC),
    parameter int REG_OUT = 1,
    parameter int CNTW    = 8
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [NSRC*WIDTH-1:0]   src_bus,
    input  logic [NSRC-1:0]         src_out_en,
    input  logic                    cnt_clr,
    output logic [WIDTH-1:0]        bus_out,
    output logic                    bus_valid,
    output logic [SELW-1:0]         sel_code,
    output logic                    conflict,
    output logic [CNTW-1:0]         conflict_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [NSRC-1:0]  en_low_s;
    logic [WIDTH-1:0] win_word_s;
    logic [SELW-1:0]  win_idx_s;
    logic             any_en_s;
    logic             multi_s;

    logic [WIDTH-1:0] hold_d, hold_q;
    logic [SELW-1:0]  hold_sel_d, hold_sel_q;
    logic             conflict_d, conflict_q;
    logic [CNTW-1:0]  cnt_d, cnt_q;

    // Fixed-priority winner: isolate the lowest set enable, then AND-OR the sources.
    always_comb begin
        en_low_s   = src_out_en & (~src_out_en + NSRC'(1));
        win_word_s = '0;
        win_idx_s  = '0;
        for (int i = 0; i < NSRC; i++) begin
            win_word_s = win_word_s | ({WIDTH{en_low_s[i]}} & src_bus[i*WIDTH +: WIDTH]);
            win_idx_s  = win_idx_s  | ({SELW{en_low_s[i]}} & SELW'(i));
        end
        any_en_s = |src_out_en;
        multi_s  = |(src_out_en & (src_out_en - NSRC'(1)));
    end

    // Next-state for the hold register and conflict tracking; clear beats increment.
    always_comb begin
        hold_d     = any_en_s ? win_word_s : hold_q;
        hold_sel_d = any_en_s ? win_idx_s  : hold_sel_q;
        conflict_d = multi_s;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (multi_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNTW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            hold_q     <= '0;
            hold_sel_q <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_sel_q <= hold_sel_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic valid_d, valid_q;

            always_comb begin
                valid_d = any_en_s;
            end

            // Registered bus-valid flag tracking last cycle's drive.
            always_ff @(posedge clock or negedge clear) begin
                if (!clear) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                end
            end

            assign bus_out   = hold_q;
            assign sel_code  = hold_sel_q;
            assign bus_valid = valid_q;
        end else begin : g_comb
            // Zero-latency path while driven; falls back to the held word otherwise.
            assign bus_out   = any_en_s ? win_word_s : hold_q;
            assign sel_code  = any_en_s ? win_idx_s  : hold_sel_q;
            assign bus_valid = any_en_s;
        end
    endgenerate

endmodule

// File: tb/tb_bus_mux_hold.sv
// Directed bench for bus_mux_hold: a registered 32x25 instance and a
// combinational 16x4 instance, each checked against hand-computed values.
module tb_bus_mux_hold;

    logic            clock;
    logic            clear_r, clear_c;
    logic [799:0]    src_r;
    logic [24:0]     en_r;
    logic            cnt_clr_r;
    logic [31:0]     bus_r;
    logic            valid_r;
    logic [4:0]      sel_r;
    logic            conf_r;
    logic [7:0]      cnt_r;

    logic [63:0]     src_c;
    logic [3:0]      en_c;
    logic            cnt_clr_c;
    logic [15:0]     bus_c;
    logic            valid_c;
    logic [1:0]      sel_c;
    logic            conf_c;
    logic [7:0]      cnt_c;

    int checks = 0;
    int errors = 0;

    bus_mux_hold #(.WIDTH(32), .NSRC(25), .REG_OUT(1), .CNTW(8)) dut_r (
        .clock(clock), .clear(clear_r), .src_bus(src_r), .src_out_en(en_r),
        .cnt_clr(cnt_clr_r), .bus_out(bus_r), .bus_valid(valid_r),
        .sel_code(sel_r), .conflict(conf_r), .conflict_cnt(cnt_r)
    );

    bus_mux_hold #(.WIDTH(16), .NSRC(4), .REG_OUT(0), .CNTW(8)) dut_c (
        .clock(clock), .clear(clear_c), .src_bus(src_c), .src_out_en(en_c),
        .cnt_clr(cnt_clr_c), .bus_out(bus_c), .bus_valid(valid_c),
        .sel_code(sel_c), .conflict(conf_c), .conflict_cnt(cnt_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_r = 1'b0; clear_c = 1'b0;
        en_r = '0; en_c = '0; src_r = '0; src_c = '0;
        cnt_clr_r = 1'b0; cnt_clr_c = 1'b0;
        tick(); tick();
        clear_r = 1'b1; clear_c = 1'b1;
        tick(); tick(); tick();
        checks++; if (bus_r !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h exp 0", bus_r); end
        checks++; if (sel_r !== 5'd0) begin errors++; $display("FAIL reset_sel: got %0d exp 0", sel_r); end
        checks++; if (valid_r !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_r); end
        checks++; if (conf_r !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b exp 0", conf_r); end
        checks++; if (cnt_r !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", cnt_r); end
        checks++; if (bus_c !== 16'h0 || valid_c !== 1'b0) begin errors++; $display("FAIL reset_comb: got %h/%b exp 0/0", bus_c, valid_c); end
    endtask

    task automatic test_hold();
        src_r[3*32 +: 32] = 32'hDEADBEEF;
        en_r = '0; en_r[3] = 1'b1;
        tick();
        checks++; if (bus_r !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_drive_bus: got %h exp deadbeef", bus_r); end
        checks++; if (sel_r !== 5'd3) begin errors++; $display("FAIL hold_drive_sel: got %0d exp 3", sel_r); end
        checks++; if (valid_r !== 1'b1) begin errors++; $display("FAIL hold_drive_valid: got %b exp 1", valid_r); end
        en_r = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (bus_r !== 32'hDEADBEEF || sel_r !== 5'd3) begin errors++; $display("FAIL hold_keep: got %h/%0d exp deadbeef/3", bus_r, sel_r); end
            checks++; if (valid_r !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b exp 0", valid_r); end
        end
    endtask

    task automatic test_back_to_back();
        src_r[20*32 +: 32] = 32'h100;
        src_r[21*32 +: 32] = 32'h200;
        en_r = '0; en_r[20] = 1'b1;
        tick();
        checks++; if (bus_r !== 32'h100 || sel_r !== 5'd20 || valid_r !== 1'b1) begin errors++; $display("FAIL b2b_first: got %h/%0d/%b exp 100/20/1", bus_r, sel_r, valid_r); end
        en_r = '0; en_r[21] = 1'b1;
        tick();
        checks++; if (bus_r !== 32'h200 || sel_r !== 5'd21 || valid_r !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%0d/%b exp 200/21/1", bus_r, sel_r, valid_r); end
        en_r = '0;
        tick();
    endtask

    task automatic test_conflict();
        src_r[5*32 +: 32] = 32'h55;
        src_r[9*32 +: 32] = 32'h99;
        en_r = '0; en_r[5] = 1'b1; en_r[9] = 1'b1;
        tick();
        checks++; if (bus_r !== 32'h55 || sel_r !== 5'd5) begin errors++; $display("FAIL conflict_winner: got %h/%0d exp 55/5", bus_r, sel_r); end
        checks++; if (conf_r !== 1'b1) begin errors++; $display("FAIL conflict_pulse: got %b exp 1", conf_r); end
        checks++; if (cnt_r !== 8'd1) begin errors++; $display("FAIL conflict_cnt: got %0d exp 1", cnt_r); end
        en_r = '0;
        tick();
        checks++; if (conf_r !== 1'b0 || cnt_r !== 8'd1) begin errors++; $display("FAIL conflict_end: got %b/%0d exp 0/1", conf_r, cnt_r); end
        checks++; if (bus_r !== 32'h55 || valid_r !== 1'b0) begin errors++; $display("FAIL conflict_hold: got %h/%b exp 55/0", bus_r, valid_r); end
    endtask

    task automatic test_saturate();
        en_r = '0; en_r[5] = 1'b1; en_r[9] = 1'b1;
        for (int k = 0; k < 253; k++) tick();
        checks++; if (cnt_r !== 8'd254) begin errors++; $display("FAIL sat_pre: got %0d exp 254", cnt_r); end
        for (int k = 0; k < 47; k++) tick();
        checks++; if (cnt_r !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d exp 255", cnt_r); end
        checks++; if (conf_r !== 1'b1) begin errors++; $display("FAIL sat_conflict: got %b exp 1", conf_r); end
        cnt_clr_r = 1'b1;
        tick();
        checks++; if (cnt_r !== 8'd0) begin errors++; $display("FAIL clr_wins: got %0d exp 0", cnt_r); end
        cnt_clr_r = 1'b0; en_r = '0;
        tick();
        checks++; if (cnt_r !== 8'd0 || conf_r !== 1'b0) begin errors++; $display("FAIL clr_after: got %0d/%b exp 0/0", cnt_r, conf_r); end
    endtask

    task automatic test_comb_path();
        src_c[1*16 +: 16] = 16'hAAAA;
        src_c[3*16 +: 16] = 16'hBBBB;
        en_c = 4'b1010;
        #1;
        checks++; if (bus_c !== 16'hAAAA || sel_c !== 2'd1 || valid_c !== 1'b1) begin errors++; $display("FAIL comb_prio: got %h/%0d/%b exp aaaa/1/1", bus_c, sel_c, valid_c); end
        tick();
        checks++; if (conf_c !== 1'b1 || cnt_c !== 8'd1) begin errors++; $display("FAIL comb_conflict: got %b/%0d exp 1/1", conf_c, cnt_c); end
        src_c[2*16 +: 16] = 16'h1234;
        en_c = 4'b0100;
        #1;
        checks++; if (bus_c !== 16'h1234 || sel_c !== 2'd2 || valid_c !== 1'b1) begin errors++; $display("FAIL comb_same_cycle: got %h/%0d/%b exp 1234/2/1", bus_c, sel_c, valid_c); end
        tick();
        en_c = 4'b0000;
        #1;
        checks++; if (bus_c !== 16'h1234 || sel_c !== 2'd2 || valid_c !== 1'b0) begin errors++; $display("FAIL comb_hold: got %h/%0d/%b exp 1234/2/0", bus_c, sel_c, valid_c); end
        tick();
        checks++; if (bus_c !== 16'h1234 || conf_c !== 1'b0) begin errors++; $display("FAIL comb_hold2: got %h/%b exp 1234/0", bus_c, conf_c); end
        #1;
        clear_c = 1'b0;
        #1;
        checks++; if (bus_c !== 16'h0 || sel_c !== 2'd0 || valid_c !== 1'b0) begin errors++; $display("FAIL comb_async_clear: got %h/%0d/%b exp 0/0/0", bus_c, sel_c, valid_c); end
        checks++; if (cnt_c !== 8'd0) begin errors++; $display("FAIL comb_clear_cnt: got %0d exp 0", cnt_c); end
        clear_c = 1'b1;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_back_to_back();
        test_conflict();
        test_saturate();
        test_comb_path();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_mux_hold.md
# bus_mux_hold

Parametrised successor to the datapath bus multiplexer. It selects one of NSRC source words onto the shared bus using one-hot drive enables (the Rout/PCout/MDRout style control signals) rather than an encoded select. It holds the last driven word in a register when no source is enabled, and detects and counts multi-driver conflicts. It sits between the register file/special registers and every Rin-loaded register, and serves as the single bus driver for the control unit.

## Interface
- WIDTH, 32, bus word width in bits (≥1)
- NSRC, 25, number of bus sources (2..64)
- SELW, $clog2(NSRC), width of encoded source index (derived, not overridden)
- REG_OUT, 1, 1 = bus_out registered (1-cycle latency); 0 = bus_out combinational from current enables
- CNTW, 8, width of saturating conflict counter
- clock  input  1  rising-edge clock
- clear  input  1  asynchronous, active-low reset
- src_bus  input  NSRC*WIDTH  packed source words; source i at bits [i*WIDTH +: WIDTH]
- src_out_en  input  NSRC  drive enables, one-hot expected; bit i = source i drives
- cnt_clr  input  1  synchronous clear of conflict_cnt
- bus_out  output  WIDTH  bus value
- bus_valid  output  1  1 = bus_out reflects a source driven this cycle (REG_OUT=0) or last cycle (REG_OUT=1); 0 = held value
- sel_code  output  SELW  index of the source currently shown on bus_out (held with bus_out)
- conflict  output  1  registered one-cycle pulse: previous cycle had ≥2 enables set
- conflict_cnt  output  CNTW  saturating count of conflict cycles

## Operation
- Winner: the lowest set index of src_out_en (fixed priority), win_idx. any_en = |src_out_en.
- Hold register hold_q (WIDTH) and hold_sel_q (SELW) load the winner's word and index on every clock edge with any_en=1. With any_en=0 they keep their value; the bus never floats or latches combinationally.
- REG_OUT=1: bus_out = hold_q, sel_code = hold_sel_q, bus_valid = registered any_en.
- REG_OUT=0: when any_en=1, bus_out = winner word, sel_code = win_idx, bus_valid = 1. Otherwise bus_out = hold_q, sel_code = hold_sel_q, bus_valid = 0.
- Conflict: multi = popcount(src_out_en) ≥ 2, computed without popcount arithmetic (x & (x-1) ≠ 0). conflict is registered multi. conflict_cnt increments on every cycle with multi=1 and saturates at 2^CNTW-1. The winner is still driven on a conflict; it is never blanked.
- cnt_clr=1 zeroes conflict_cnt at the next edge. If multi=1 in the same cycle, the clear wins and the count becomes 0, not 1.
- Source indices ≥ NSRC do not exist; any unused high bits of sel_code stay 0.
- Reset (clear=0, asynchronous): hold_q=0, hold_sel_q=0, bus_valid register=0, conflict=0, conflict_cnt=0. After reset with no enables, bus_out=0, sel_code=0, bus_valid=0. Deasserting clear mid-transfer loses the transfer; the first edge after release samples normally.

## Timing
- REG_OUT=1: src_out_en/src_bus sampled at edge N; bus_out/sel_code/bus_valid valid after edge N (1-cycle latency). The control unit asserts Rout in T(k) and Rin in T(k+1).
- REG_OUT=0: zero-latency combinational path from src_out_en/src_bus to bus_out. The hold register still updates at the edge.
- conflict pulses for exactly one cycle after each conflict cycle, independent of REG_OUT. conflict_cnt updates at the same edge.
- Back-to-back different sources in consecutive cycles are supported with no bubble.
- Asynchronous clear takes effect without a clock edge. All outputs except the REG_OUT=0 combinational path reach reset values immediately.

## Test plan
- Reset, then enables=0 for 3 cycles -> bus_out=0, sel_code=0, bus_valid=0, conflict=0, conflict_cnt=0.
- REG_OUT=1, source 3 = 0xDEADBEEF with en bit 3 for 1 cycle, then en=0 -> next cycle bus_out=0xDEADBEEF, sel_code=3, bus_valid=1; the following cycles hold 0xDEADBEEF with bus_valid=0.
- Sources 20 (PC=0x100) and 21 (MDR=0x200) enabled in consecutive cycles -> bus_out 0x100 then 0x200 on successive cycles, sel_code 20 then 21, no bubble.
- Enables bits 5 and 9 set together (R5=0x55, R9=0x99) -> bus_out=0x55, sel_code=5, conflict=1 for one cycle, conflict_cnt=1.
- 300 consecutive conflict cycles with CNTW=8 -> conflict_cnt saturates at 255. cnt_clr together with a conflict -> conflict_cnt=0.
- REG_OUT=0, WIDTH=16, NSRC=4: en=0b0100 with src2=0x1234 -> bus_out=0x1234 in the same cycle. Drop en -> 0x1234 held, bus_valid=0. Assert clear mid-hold -> bus_out=0 immediately.
